instr_fetch: RTL and testbench

Instruction fetch unit that produces the instruction stream consumed by the main control decoder. It holds the program counter and issues single-outstanding requests to instruction memory over a req/ack handshake. It presents each fetched word, with its 6-bit opcode field split out, to decode over a valid/ready handshake. When decode accepts a word, the unit selects the next PC from the decoder's jump/branch outputs and the ALU zero flag.

---
 rtl/instr_fetch_pkg.sv | 36 +++
 rtl/instr_fetch_pc_next_sel.sv | 42 ++++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 tb/tb_instr_fetch.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
//
// Shared definitions for the instruction fetch slice:
//   - opcode constants for the instruction classes the main decoder knows
//   - fetch FSM state encoding
//   - default first-fetch address
//   - helper that turns a 16-bit branch immediate into a byte offset
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

    // First fetch address after reset; must be word aligned.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Opcode field values (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // IDLE only lasts for the first cycle out of reset, FETCH waits for the
    // memory ack and HOLD waits for decode to take the word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Sign-extend a word-granular branch immediate and scale it to bytes.
    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
//
// Purely combinational next-PC selection used when decode accepts a word.
//
// Ports:
//   pc_plus4  in  32  address of the accepted instruction plus 4
//   instr     in  32  accepted instruction word
//   jump      in  1   decoder jump control
//   branch    in  1   decoder branch control
//   zero      in  1   ALU zero flag
//   next_pc   out 32  address of the next fetch
// ----------------------------------------------------------------------------
module pc_next_sel (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc
);
    import instr_fetch_pkg::*;

    // The opcode field plays no part in target selection; the decoder has
    // already condensed it into jump/branch.
    logic unusedInstrBits;
    assign unusedInstrBits = ^instr[31:26];

    // Jump is checked first so it wins when the decoder raises both
    // controls. The jump target keeps the top nibble of the sequential
    // address (same 256 MB region); a taken branch is relative to pc+4 and
    // simply wraps at 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branchOffset(instr[15:0]);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. Holds the PC, issues one outstanding request at a
// time to instruction memory (req/ack) and presents the returned word to
// decode (valid/ready). On accept it picks the next PC from jump/branch/zero.
//
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   imem_req     out 1   fetch request, held until imem_ack
//   imem_addr    out 32  word-aligned fetch address, stable while requesting
//   imem_ack     in  1   imem_rdata is valid this cycle
//   imem_rdata   in  32  returned instruction word
//   instr        out 32  fetched instruction
//   opcode       out 6   instr[31:26]
//   instr_valid  out 1   instr/opcode/pc are valid
//   instr_ready  in  1   decode accepts the current instruction
//   jump         in  1   decoder jump control for the accepted word
//   branch       in  1   decoder branch control for the accepted word
//   zero         in  1   ALU zero flag for the accepted word
//   pc           out 32  address of instr
//   pc_plus4     out 32  pc + 4
//   icount       out 32  number of accepted instructions (wraps)
// ----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] icount
);

    fetch_state_e state_q, state_d;
    logic        imemReq_q, imemReq_d;
    logic [31:0] imemAddr_q, imemAddr_d;
    logic [31:0] instr_q, instr_d;
    logic        instrValid_q, instrValid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] icount_q, icount_d;
    logic [31:0] pcPlus4;
    logic [31:0] nextPc;

    assign pcPlus4 = pc_q + 32'd4;

    pc_next_sel u_pc_next_sel (
        .pc_plus4 (pcPlus4),
        .instr    (instr_q),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .next_pc  (nextPc)
    );

    // Next-state logic. Everything holds by default, so an ack outside FETCH
    // or jump/branch/zero outside the accept cycle have no effect. Because
    // only one request is ever in flight, a redirect just loads the new
    // address; there is nothing to flush.
    always_comb begin
        state_d      = state_q;
        imemReq_d    = imemReq_q;
        imemAddr_d   = imemAddr_q;
        instr_d      = instr_q;
        instrValid_d = instrValid_q;
        pc_d         = pc_q;
        icount_d     = icount_q;

        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                imemReq_d  = 1'b1;
                imemAddr_d = RESET_PC;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d      = imem_rdata;
                    pc_d         = imemAddr_q;
                    instrValid_d = 1'b1;
                    imemReq_d    = 1'b0;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    icount_d     = icount_q + 32'd1;
                    instrValid_d = 1'b0;
                    imemReq_d    = 1'b1;
                    imemAddr_d   = nextPc;
                    state_d      = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset wins over everything, including an ack that
    // lands on the same edge, so an in-flight request is simply abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            imemReq_q    <= 1'b0;
            imemAddr_q   <= RESET_PC;
            instr_q      <= 32'd0;
            instrValid_q <= 1'b0;
            pc_q         <= RESET_PC;
            icount_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            imemReq_q    <= imemReq_d;
            imemAddr_q   <= imemAddr_d;
            instr_q      <= instr_d;
            instrValid_q <= instrValid_d;
            pc_q         <= pc_d;
            icount_q     <= icount_d;
        end
    end

    assign imem_req    = imemReq_q;
    assign imem_addr   = imemAddr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instrValid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pcPlus4;
    assign icount      = icount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. Acts as instruction memory and as the
// decode stage, and predicts fetch addresses, presented words and the
// accepted-instruction count from a small behavioural model.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] icount;

    int checks = 0;
    int errors = 0;

    // Model state: address the next request should carry, and accepted count.
    logic [31:0] expAddr;
    logic [31:0] expIcount;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .icount      (icount)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural next-address rule, written with plain arithmetic.
    function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic j, input logic b, input logic z);
        logic [31:0] seqPc;
        int          offset;
        seqPc = curPc + 32'd4;
        if (j) return (seqPc & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (b && z) begin
            offset = $signed(word[15:0]);
            return seqPc + 32'(offset * 4);
        end
        return seqPc;
    endfunction

    // Memory side: wait (bounded) for a request, note its address, answer
    // after 'delay' cycles. Returns on the negedge after the ack edge.
    task automatic applyStimulus(input logic [31:0] word, input int delay,
                                 output logic [31:0] addrSeen, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            ok       = 1'b0;
            addrSeen = 32'hxxxx_xxxx;
            return;
        end
        addrSeen = imem_addr;
        repeat (delay) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Decode side: stall, then accept with the given controls. During the
    // stall the controls are junk, which the DUT must ignore.
    task automatic acceptInstr(input logic j, input logic b, input logic z, input int stall);
        repeat (stall) begin
            instr_ready = 1'b0;
            jump        = 1'($urandom);
            branch      = 1'($urandom);
            zero        = 1'($urandom);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        jump        = j;
        branch      = b;
        zero        = z;
        @(negedge clk);
        instr_ready = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        expIcount   = expIcount + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0)      begin errors++; $display("[TB] FAIL rst_req: got %b required 0", imem_req); end
        checks++; if (imem_addr !== RST_PC)   begin errors++; $display("[TB] FAIL rst_addr: got %h required %h", imem_addr, RST_PC); end
        checks++; if (instr !== 32'd0)        begin errors++; $display("[TB] FAIL rst_instr: got %h required 0", instr); end
        checks++; if (instr_valid !== 1'b0)   begin errors++; $display("[TB] FAIL rst_valid: got %b required 0", instr_valid); end
        checks++; if (pc !== RST_PC)          begin errors++; $display("[TB] FAIL rst_pc: got %h required %h", pc, RST_PC); end
        checks++; if (icount !== 32'd0)       begin errors++; $display("[TB] FAIL rst_icount: got %0d required 0", icount); end
        reset = 1'b0;
        checks++; if (imem_req !== 1'b0)      begin errors++; $display("[TB] FAIL rst_req_early: got %b required 0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++; $display("[TB] FAIL rst_first_req: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
        expAddr   = RST_PC;
        expIcount = 32'd0;
    endtask

    task automatic test_sequential();
        logic [31:0] word, addr;
        logic        ok;
        for (int i = 0; i < 3; i++) begin
            word = $urandom;
            applyStimulus(word, 2, addr, ok);
            checks++; if (!ok || addr !== RST_PC + 32'(4 * i)) begin
                errors++; $display("[TB] FAIL seq_addr%0d: got %h (ok=%b) required %h", i, addr, ok, RST_PC + 32'(4 * i));
            end
            checks++; if (instr_valid !== 1'b1 || instr !== word || pc !== addr) begin
                errors++; $display("[TB] FAIL seq_word%0d: got v=%b instr=%h pc=%h required v=1 instr=%h pc=%h", i, instr_valid, instr, pc, word, addr);
            end
            acceptInstr(1'b0, 1'b0, 1'b0, 0);
            expAddr = refNextPc(addr, word, 1'b0, 1'b0, 1'b0);
        end
        checks++; if (icount !== 32'd3) begin errors++; $display("[TB] FAIL seq_icount: got %0d required 3", icount); end
    endtask

    task automatic test_backpressure();
        logic [31:0] word, addr;
        logic        ok;
        word = $urandom;
        applyStimulus(word, 1, addr, ok);
        checks++; if (!ok || addr !== expAddr) begin errors++; $display("[TB] FAIL bp_addr: got %h required %h", addr, expAddr); end
        for (int c = 0; c < 5; c++) begin
            instr_ready = 1'b0;
            jump        = 1'($urandom);
            branch      = 1'($urandom);
            zero        = 1'($urandom);
            imem_rdata  = $urandom;
            @(negedge clk);
            checks++; if (instr !== word || pc !== expAddr || instr_valid !== 1'b1 || imem_req !== 1'b0 || icount !== expIcount) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got instr=%h pc=%h v=%b req=%b cnt=%0d required instr=%h pc=%h v=1 req=0 cnt=%0d",
                         c, instr, pc, instr_valid, imem_req, icount, word, expAddr, expIcount);
            end
        end
        acceptInstr(1'b0, 1'b0, 1'b0, 0);
        expAddr = refNextPc(addr, word, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_beq();
        logic [31:0] addr;
        logic        ok;
        applyStimulus(32'h1000_FFFE, 0, addr, ok);
        checks++; if (!ok || addr !== 32'h0000_0010) begin errors++; $display("[TB] FAIL beq_pc: got %h required 00000010", addr); end
        checks++; if (opcode !== 6'b000100 || pc_plus4 !== 32'h0000_0014) begin
            errors++; $display("[TB] FAIL beq_decode: got op=%b pc4=%h required op=000100 pc4=00000014", opcode, pc_plus4);
        end
        acceptInstr(1'b0, 1'b1, 1'b1, 2);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_000C) begin
            errors++; $display("[TB] FAIL beq_taken: got req=%b addr=%h required req=1 addr=0000000c", imem_req, imem_addr);
        end
        applyStimulus(32'h0000_0020, 1, addr, ok);
        acceptInstr(1'b0, 1'b0, 1'b0, 0);
        applyStimulus(32'h1000_FFFE, 0, addr, ok);
        acceptInstr(1'b0, 1'b1, 1'b0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0014) begin
            errors++; $display("[TB] FAIL beq_not_taken: got req=%b addr=%h required req=1 addr=00000014", imem_req, imem_addr);
        end
        expAddr = 32'h0000_0014;
    endtask

    // Jump to 0x20, then climb with maximum forward branches into the
    // 0x4000_0000 region; each step advances exactly 0x20000.
    task automatic test_branch_climb();
        logic [31:0] addr;
        logic        ok, allOk;
        applyStimulus(32'h0800_0008, 0, addr, ok);
        acceptInstr(1'b1, 1'b0, 1'b0, 0);
        expAddr = refNextPc(addr, 32'h0800_0008, 1'b1, 1'b0, 1'b0);
        checks++; if (!ok || imem_addr !== 32'h0000_0020) begin errors++; $display("[TB] FAIL j_to_20: got %h required 00000020", imem_addr); end
        allOk = 1'b1;
        for (int s = 0; s < 8192; s++) begin
            applyStimulus(32'h1000_7FFF, 0, addr, ok);
            if (!ok || addr !== expAddr) begin
                allOk = 1'b0;
                break;
            end
            acceptInstr(1'b0, 1'b1, 1'b1, 0);
            expAddr = refNextPc(addr, 32'h1000_7FFF, 1'b0, 1'b1, 1'b1);
        end
        checks++; if (!allOk || imem_addr !== 32'h4000_0020 || expAddr !== 32'h4000_0020) begin
            errors++; $display("[TB] FAIL climb: got addr=%h steps_ok=%b required 40000020", imem_addr, allOk);
        end
    endtask

    task automatic test_jump_priority();
        logic [31:0] addr;
        logic        ok;
        applyStimulus(32'h0800_0040, 1, addr, ok);
        checks++; if (!ok || pc !== 32'h4000_0020) begin errors++; $display("[TB] FAIL jmp_pc: got %h required 40000020", pc); end
        acceptInstr(1'b1, 1'b0, 1'b0, 1);
        checks++; if (imem_addr !== 32'h4000_0100) begin errors++; $display("[TB] FAIL jmp_target: got %h required 40000100", imem_addr); end
        applyStimulus(32'h0800_0008, 0, addr, ok);
        acceptInstr(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(32'h0800_0040, 0, addr, ok);
        checks++; if (!ok || addr !== 32'h4000_0020) begin errors++; $display("[TB] FAIL jmp_back: got %h required 40000020", addr); end
        acceptInstr(1'b1, 1'b1, 1'b1, 0);
        checks++; if (imem_addr !== 32'h4000_0100) begin errors++; $display("[TB] FAIL jmp_priority: got %h required 40000100", imem_addr); end
        expAddr = 32'h4000_0100;
    endtask

    task automatic test_stray_ack();
        logic [31:0] word, addr, junk;
        logic        ok;
        word = $urandom;
        applyStimulus(word, 1, addr, ok);
        for (int c = 0; c < 2; c++) begin
            imem_ack   = 1'b1;
            junk       = ~word;
            imem_rdata = junk;
            @(negedge clk);
            imem_ack = 1'b0;
            checks++; if (instr !== word || pc !== expAddr || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("[TB] FAIL stray_hold%0d: got instr=%h pc=%h v=%b req=%b required instr=%h pc=%h v=1 req=0",
                                   c, instr, pc, instr_valid, imem_req, word, expAddr);
            end
        end
        acceptInstr(1'b0, 1'b0, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr !== 32'd0 || instr_valid !== 1'b0 || pc !== RST_PC || imem_req !== 1'b1 || imem_addr !== RST_PC || icount !== 32'd0) begin
            errors++; $display("[TB] FAIL stray_idle: got instr=%h v=%b pc=%h req=%b addr=%h cnt=%0d required 0/0/%h/1/%h/0",
                               instr, instr_valid, pc, imem_req, imem_addr, icount, RST_PC, RST_PC);
        end
        expIcount = 32'd0;
        word = $urandom;
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== word || pc !== RST_PC) begin
            errors++; $display("[TB] FAIL same_cycle_ack: got v=%b instr=%h pc=%h required v=1 instr=%h pc=%h", instr_valid, instr, pc, word, RST_PC);
        end
        acceptInstr(1'b0, 1'b0, 1'b0, 0);
        expAddr = refNextPc(RST_PC, word, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        checks++; if (imem_req !== 1'b1 || imem_addr !== expAddr || icount !== 32'd1) begin
            errors++; $display("[TB] FAIL mr_pre: got req=%b addr=%h cnt=%0d required req=1 addr=%h cnt=1", imem_req, imem_addr, icount, expAddr);
        end
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b0 || imem_addr !== RST_PC || instr !== 32'd0 || instr_valid !== 1'b0 || pc !== RST_PC || icount !== 32'd0) begin
            errors++; $display("[TB] FAIL mr_state: got req=%b addr=%h instr=%h v=%b pc=%h cnt=%0d required reset values",
                               imem_req, imem_addr, instr, instr_valid, pc, icount);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++; $display("[TB] FAIL mr_refetch: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
        expAddr   = RST_PC;
        expIcount = 32'd0;
    endtask

    task automatic test_random();
        logic [31:0] word, addr;
        logic        ok, j, b, z;
        for (int i = 0; i < 60; i++) begin
            word = $urandom;
            j    = ($urandom_range(3, 0) == 0);
            b    = 1'($urandom);
            z    = 1'($urandom);
            applyStimulus(word, $urandom_range(3, 0), addr, ok);
            if (!ok) begin
                checks++; errors++;
                $display("[TB] FAIL rnd_timeout%0d: got no request required request at %h", i, expAddr);
                break;
            end
            checks++; if (addr !== expAddr) begin errors++; $display("[TB] FAIL rnd_addr%0d: got %h required %h", i, addr, expAddr); end
            checks++; if (instr_valid !== 1'b1 || instr !== word || opcode !== word[31:26] || pc !== expAddr || pc_plus4 !== expAddr + 32'd4) begin
                errors++; $display("[TB] FAIL rnd_word%0d: got v=%b instr=%h op=%h pc=%h pc4=%h required v=1 instr=%h pc=%h",
                                   i, instr_valid, instr, opcode, pc, pc_plus4, word, expAddr);
            end
            acceptInstr(j, b, z, $urandom_range(3, 0));
            expAddr = refNextPc(expAddr, word, j, b, z);
            checks++; if (icount !== expIcount) begin errors++; $display("[TB] FAIL rnd_icount%0d: got %0d required %0d", i, icount, expIcount); end
        end
    endtask

    task automatic checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // Scenario sequence; each test leaves the DUT in FETCH at expAddr.
    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        expAddr     = RST_PC;
        expIcount   = 32'd0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_beq();
        test_branch_climb();
        test_jump_priority();
        test_stray_ack();
        test_mid_reset();
        test_random();
        checkOutput();
        $finish;
    end

endmodule
